wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the five-stage RV32I pipeline, directly downstream of the data-memory stage. Captures EX/MEM control and results on the same edge the memory stage registers its load data. Extracts and sign/zero-extends sub-word loads, selects the write-back value and drives the register-file write port. Also provides a one-entry hold buffer for pipeline stalls, misaligned-load detection and a retired-instruction counter.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `in_valid` in 1: EX/MEM slot holds a live instruction.
- `in_kill` in 1: flush; the incoming instruction is captured as invalid.
- `in_reg_write` in 1: instruction writes `rd`.
- `in_wb_sel` in 2: 00 ALU, 01 memory, 10 `pc_plus4`, 11 reserved (treated as ALU).
- `in_funct3` in 3: load width/sign code.
- `in_rd` in 5: destination register.
- `in_alu_result` in 32: ALU result; for loads, the byte address.
- `in_pc_plus4` in 32: link value for JAL/JALR.
- `mem_data` in 32: registered word from the memory stage, valid the cycle after the load address.
- `hold` in 1: hazard-unit stall of this stage.
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out 5: write address.
- `rf_wdata` out 32: write data; also the forwarding source.
- `load_misaligned` out 1: misaligned load is resident in the stage.
- `instret` out 64: retired-instruction count.

## Operation
- W register captures `valid = in_valid & ~in_kill`, `reg_write`, `wb_sel`, `funct3`, `rd`, `alu_result` and `pc_plus4` on each rising edge where `hold` = 0. While `hold` = 1, W holds its contents.
- Load word source is `buf_valid ? load_buf : mem_data`.
- On a cycle with W valid, `wb_sel` = 01, `hold` = 1 and `buf_valid` = 0: latch `mem_data` into `load_buf` and set `buf_valid`. The flag clears on the first edge with `hold` = 0.
- Load extraction, with byte lane = `alu_result[1:0]` and half lane = `alu_result[1]`:
  - 000 lb: sign-extend the selected byte.
  - 100 lbu: zero-extend the selected byte.
  - 001 lh: sign-extend the selected half.
  - 101 lhu: zero-extend the selected half.
  - 010 lw, and any other code: the full word.
- Misaligned (memory loads only, `wb_sel` = 01): lh/lhu with `addr[0]`=1, or lw with `addr[1:0]`≠0. Asserts `load_misaligned`, which is combinational from W and independent of `hold`, and forces `rf_we` = 0.
- `rf_we = W.valid & W.reg_write & (rd≠0) & ~hold & ~misaligned`.
- `rf_waddr` = W.rd.
- `rf_wdata` is the selected source. It is driven regardless of `rf_we`.
- `instret` increments by 1 on each edge where W is valid, `hold` = 0 and the load is not misaligned. It wraps at 2^64−1 to 0.

## Timing
- Instruction presented at cycle N is resident in W during N+1.
- The register file writes at the end of N+1, so write-back latency is 1 cycle.
- `mem_data` for a load issued to the memory stage in N is valid in N+1, aligned with W.
- While stalled: write is deferred to the first cycle with `hold` = 0, exactly once, using `load_buf` if the stall began while the load was resident.
- Back-to-back unstalled instructions retire one per cycle.
- Reset asserted: W.valid = 0, all W fields = 0, `buf_valid` = 0, `load_buf` = 0, `instret` = 0.
  - Outputs read `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0 and `load_misaligned` = 0 immediately, without waiting for a clock.
- Reset mid-stall discards the held instruction; no write occurs.
- `in_kill` together with `hold`: `hold` wins and W is unchanged. The kill applies to the incoming slot only when it is captured.

## Structure
- Shared `riscv_pkg` holds:
  - WB_SEL_ALU / WB_SEL_MEM / WB_SEL_PC constants.
  - F3_LB / LH / LW / LBU / LHU load codes.
- Sub-module `load_align` (combinational): inputs word, `addr[1:0]`, `funct3`; outputs extended data and misaligned flag.
- All other logic lives in `wb_stage`: W register, hold buffer, counter and write-back mux.

## Test plan
- lb, addr 0x101, `mem_data` 0x1234_80FF: `rf_wdata` 0xFFFF_FF80, `rf_we` = 1 in N+1. Same with lbu: 0x0000_0080.
- lhu, addr 0x102, `mem_data` 0x1234_80FF: 0x0000_1234. lh, addr 0x100: 0xFFFF_80FF.
- lw, addr 0x106, rd = 5: `load_misaligned` = 1, `rf_we` = 0, `instret` unchanged.
- Load resident, `hold` high for 3 cycles, `mem_data` changed to 0xDEAD_BEEF after cycle 1: the single write on release carries the original word; `instret` +1 only.
- JAL with rd = 1, `pc_plus4` 0x2004: writes 0x2004. Same instruction with rd = 0: `rf_we` = 0, `instret` +1.
- Assert `reset` low with no clock edge while an instruction is resident:
  - During reset, all outputs are 0 and `instret` = 0.
  - `in_kill` during the next unstalled capture makes the slot a bubble: no write and no count.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions.
// Write-back select codes, load funct3 codes and the MEM/WB bundle.
package riscv_pkg;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
  } mem_wb_t;

endpackage

// File: rtl/load_align.sv
// Sub-word load extraction and alignment check.
// Purely combinational; unknown funct3 codes pass the full word.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b          = word[{addr, 3'b000} +: 8];
    h          = addr[1] ? word[31:16] : word[15:0];
    data       = word;
    misaligned = 1'b0;
    unique case (1'b1)
      funct3 == F3_LB:  data = {{24{b[7]}}, b};
      funct3 == F3_LBU: data = {24'd0, b};
      funct3 == F3_LH: begin
        data       = {{16{h[15]}}, h};
        misaligned = addr[0];
      end
      funct3 == F3_LHU: begin
        data       = {16'd0, h};
        misaligned = addr[0];
      end
      funct3 == F3_LW:  misaligned = (addr != 2'b00);
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage: W register, stall hold buffer,
// load alignment, write-back mux and retired-instruction counter.
module wb_stage
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_kill,
  input  logic        in_reg_write,
  input  logic [1:0]  in_wb_sel,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_pc_plus4,
  input  logic [31:0] mem_data,
  input  logic        hold,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        load_misaligned,
  output logic [63:0] instret
);

  mem_wb_t     w;
  logic [31:0] load_buf;
  logic        buf_valid;
  logic [63:0] instret_q;
  logic [31:0] ld_word;
  logic [31:0] ld_data;
  logic        align_mis;
  logic        is_load;
  logic        misaligned;

  assign ld_word    = buf_valid ? load_buf : mem_data;
  assign is_load    = w.valid & (w.wb_sel == WB_SEL_MEM);
  assign misaligned = is_load & align_mis;

  load_align u_align (
    .word       (ld_word),
    .addr       (w.alu_result[1:0]),
    .funct3     (w.funct3),
    .data       (ld_data),
    .misaligned (align_mis)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w         <= '0;
      load_buf  <= '0;
      buf_valid <= 1'b0;
      instret_q <= '0;
    end else if (!hold) begin
      w <= '{
        valid:      in_valid & ~in_kill,
        reg_write:  in_reg_write,
        wb_sel:     in_wb_sel,
        funct3:     in_funct3,
        rd:         in_rd,
        alu_result: in_alu_result,
        pc_plus4:   in_pc_plus4
      };
      buf_valid <= 1'b0;
      if (w.valid & ~misaligned)
        instret_q <= instret_q + 64'd1;
    end else if (is_load & ~buf_valid) begin
      // memory stage moves on during the stall; keep the word it gave us
      load_buf  <= mem_data;
      buf_valid <= 1'b1;
    end
  end

  always_comb begin
    unique case (w.wb_sel)
      WB_SEL_MEM: rf_wdata = ld_data;
      WB_SEL_PC:  rf_wdata = w.pc_plus4;
      default:    rf_wdata = w.alu_result;
    endcase
  end

  assign rf_we = w.valid & w.reg_write & (w.rd != 5'd0)
               & ~hold & ~misaligned;
  assign rf_waddr        = w.rd;
  assign load_misaligned = misaligned;
  assign instret         = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed test-plan cases
// followed by random traffic against a behavioural model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_kill;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [31:0] mem_data;
  logic        hold;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_misaligned;
  logic [63:0] instret;

  wb_stage dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_kill         (in_kill),
    .in_reg_write    (in_reg_write),
    .in_wb_sel       (in_wb_sel),
    .in_funct3       (in_funct3),
    .in_rd           (in_rd),
    .in_alu_result   (in_alu_result),
    .in_pc_plus4     (in_pc_plus4),
    .mem_data        (mem_data),
    .hold            (hold),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .load_misaligned (load_misaligned),
    .instret         (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v;
    bit        rw;
    bit [1:0]  sel;
    bit [2:0]  f3;
    bit [4:0]  rd;
    bit [31:0] addr;
    bit [31:0] pc;
  } instr_t;

  typedef struct {
    bit        we;
    bit [4:0]  waddr;
    bit [31:0] wdata;
    bit        mis;
    bit [63:0] ret;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  instr_t      res;
  bit [31:0]   saved[$];
  bit [63:0]   cnt;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(string name, bit [63:0] act, bit [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t",
               name, act, req, $time);
    end
  endtask

  function automatic instr_t mk(bit v, bit rw, bit [1:0] sel,
      bit [2:0] f3, bit [4:0] rd, bit [31:0] a, bit [31:0] pc);
    instr_t i;
    i.v = v; i.rw = rw; i.sel = sel; i.f3 = f3;
    i.rd = rd; i.addr = a; i.pc = pc;
    return i;
  endfunction

  function automatic bit [31:0] ref_load(bit [31:0] w,
      bit [31:0] a, bit [2:0] f3);
    int unsigned bs = a[1:0] * 8;
    int unsigned hs = a[1] ? 16 : 0;
    bit [31:0] by = (w >> bs) & 32'hFF;
    bit [31:0] hw = (w >> hs) & 32'hFFFF;
    case (f3)
      3'd0:    return (by >= 128) ? by - 32'd256 : by;
      3'd4:    return by;
      3'd1:    return (hw >= 32768) ? hw - 32'd65536 : hw;
      3'd5:    return hw;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_mis(instr_t i);
    bit half = (i.f3 == 3'd1) || (i.f3 == 3'd5);
    return i.v && i.sel == 2'd1 &&
           ((half && i.addr[0]) ||
            (i.f3 == 3'd2 && i.addr[1:0] != 2'd0));
  endfunction

  task automatic drive_model(instr_t nx, bit k, bit [31:0] md, bit h);
    exp_t      e;
    bit [31:0] word;
    bit        mis;
    in_valid      = nx.v;
    in_kill       = k;
    in_reg_write  = nx.rw;
    in_wb_sel     = nx.sel;
    in_funct3     = nx.f3;
    in_rd         = nx.rd;
    in_alu_result = nx.addr;
    in_pc_plus4   = nx.pc;
    mem_data      = md;
    hold          = h;
    word = (saved.size() != 0) ? saved[0] : md;
    mis  = ref_mis(res);
    e.we    = res.v && res.rw && res.rd != 0 && !h && !mis;
    e.waddr = res.rd;
    if (res.sel == 2'd1)      e.wdata = ref_load(word, res.addr, res.f3);
    else if (res.sel == 2'd2) e.wdata = res.pc;
    else                      e.wdata = res.addr;
    e.mis = mis;
    e.ret = cnt;
    exp_q.push_back(e);
    if (h) begin
      if (res.v && res.sel == 2'd1 && saved.size() == 0)
        saved.push_back(md);
    end else begin
      saved.delete();
      if (res.v && !mis) cnt++;
      res   = nx;
      res.v = nx.v && !k;
    end
  endtask

  task automatic step(instr_t nx, bit k, bit [31:0] md, bit h);
    @(posedge clk);
    #1;
    drive_model(nx, k, md, h);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("rf_we", 64'(rf_we), 64'(mon_e.we));
      chk("rf_waddr", 64'(rf_waddr), 64'(mon_e.waddr));
      chk("rf_wdata", 64'(rf_wdata), 64'(mon_e.wdata));
      chk("load_misaligned", 64'(load_misaligned), 64'(mon_e.mis));
      chk("instret", instret, mon_e.ret);
    end
  end

  instr_t idle;
  instr_t alu3;
  instr_t rnd;

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    alu3 = mk(1, 1, 0, 0, 3, 32'h55, 0);
    res  = idle;
    cnt  = 0;
    reset = 1'b0;
    in_valid = 0; in_kill = 0; in_reg_write = 0; in_wb_sel = 0;
    in_funct3 = 0; in_rd = 0; in_alu_result = 0; in_pc_plus4 = 0;
    mem_data = 0; hold = 0;
    #12;
    chk("reset_we", 64'(rf_we), 0);
    chk("reset_wdata", 64'(rf_wdata), 0);
    chk("reset_instret", instret, 0);
    @(negedge clk);
    #1 reset = 1'b1;

    step(mk(1, 1, 1, 3'd0, 7, 32'h101, 0), 0, 0, 0);
    step(mk(1, 1, 1, 3'd4, 8, 32'h101, 0), 0, 32'h1234_80FF, 0);
    step(mk(1, 1, 1, 3'd5, 9, 32'h102, 0), 0, 32'h1234_80FF, 0);
    step(mk(1, 1, 1, 3'd1, 10, 32'h100, 0), 0, 32'h1234_80FF, 0);
    step(mk(1, 1, 1, 3'd2, 5, 32'h106, 0), 0, 32'h1234_80FF, 0);
    step(mk(1, 1, 2, 0, 1, 32'h40, 32'h2004), 0, 32'h1234_80FF, 0);
    step(mk(1, 1, 2, 0, 0, 32'h40, 32'h2004), 0, 0, 0);
    step(mk(1, 1, 1, 3'd2, 9, 32'h200, 0), 0, 0, 0);
    step(alu3, 0, 32'h1122_3344, 1);
    step(alu3, 0, 32'hDEAD_BEEF, 1);
    step(alu3, 0, 32'hDEAD_BEEF, 1);
    step(alu3, 0, 32'hDEAD_BEEF, 0);
    step(idle, 0, 0, 0);

    step(mk(1, 1, 1, 3'd2, 4, 32'h300, 0), 0, 0, 0);
    step(alu3, 1, 32'h0000_00AA, 1);
    @(posedge clk);
    #1 reset = 1'b0;
    res = idle;
    saved.delete();
    cnt = 0;
    #1;
    chk("async_we", 64'(rf_we), 0);
    chk("async_waddr", 64'(rf_waddr), 0);
    chk("async_wdata", 64'(rf_wdata), 0);
    chk("async_mis", 64'(load_misaligned), 0);
    chk("async_instret", instret, 0);
    drive_model(mk(1, 1, 0, 0, 6, 32'h77, 0), 1, 0, 0);
    @(negedge clk);
    #1 reset = 1'b1;
    step(idle, 0, 0, 0);
    step(idle, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      rnd.v    = ($urandom_range(0, 9) < 8);
      rnd.rw   = ($urandom_range(0, 3) != 0);
      rnd.sel  = 2'($urandom_range(0, 3));
      rnd.f3   = 3'($urandom_range(0, 7));
      rnd.rd   = ($urandom_range(0, 3) == 0) ? 5'd0
               : 5'($urandom_range(1, 31));
      rnd.addr = $urandom;
      rnd.pc   = $urandom;
      step(rnd, ($urandom_range(0, 6) == 0), $urandom,
           ($urandom_range(0, 3) == 0));
    end
    step(idle, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d pending required 0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
